// File: rtl/rx_frame_receiver.sv
// -----------------------------------------------------------------------------
// rx_frame_receiver
//   Oversampling serial frame receiver for the NRZ stream coming out of the
//   Manchester decoder. It locks on an idle-high preamble, then receives
//   frames made of a start bit, N data bits, an optional parity bit and one or
//   two stop bits. Received words are offered on a valid/ready handshake.
//
// Ports
//   clk        in   1  single clock, posedge
//   rst_n      in   1  asynchronous active-low reset
//   din        in   1  serial NRZ input, idle high
//   rx_ready   in   1  consumer accepts data_out when high with rx_valid
//   data_out   out  N  received word, stable while rx_valid is high
//   rx_valid   out  1  word available, held until accepted
//   parity_err out  1  parity mismatch for data_out, qualified by rx_valid
//   frame_err  out  1  one-cycle pulse: a stop bit was sampled low
//   overrun    out  1  one-cycle pulse: word completed while rx_valid was high
//   locked     out  1  preamble seen, receiver armed
//   busy       out  1  receiving a frame (START/DATA/PARITY/STOP)
// -----------------------------------------------------------------------------
module rx_frame_receiver #(
    parameter int N             = 8,
    parameter int CLKS_PER_BIT  = 20,
    parameter int PREAMBLE_CLKS = 10,
    parameter int PARITY_EN     = 0,
    parameter int PARITY_ODD    = 0,
    parameter int STOP_BITS     = 1,
    parameter int LSB_FIRST     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         din,
    input  logic         rx_ready,
    output logic [N-1:0] data_out,
    output logic         rx_valid,
    output logic         parity_err,
    output logic         frame_err,
    output logic         overrun,
    output logic         locked,
    output logic         busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = (N > 1) ? $clog2(N + 1) : 1;
    localparam int PW = (PREAMBLE_CLKS > 1) ? $clog2(PREAMBLE_CLKS + 1) : 1;

    localparam logic [BW-1:0] HALF_M1   = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(PREAMBLE_CLKS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_HUNT   = 3'd0,
        S_ARMED  = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    state_t          state_q;
    logic            sync1_q;
    logic            ds_q;
    logic            ds_prev_q;
    logic [BW-1:0]   bit_cnt_q;
    logic [IW-1:0]   idx_q;
    logic [PW-1:0]   pre_cnt_q;
    logic            stop_cnt_q;
    logic [N-1:0]    shreg_q;
    logic            par_bad_q;
    logic [N-1:0]    data_q;
    logic            rx_valid_q;
    logic            parity_err_q;
    logic            frame_err_q;
    logic            overrun_q;
    logic            locked_q;
    logic            busy_q;

    // Insert one received bit into the shift register in the configured order.
    function automatic logic [N-1:0] shift_in(input logic [N-1:0] cur, input logic b);
        logic [N-1:0] r;
        if (LSB_FIRST != 0) begin
            r        = cur >> 1;
            r[N-1]   = b;
        end else begin
            r        = cur << 1;
            r[0]     = b;
        end
        return r;
    endfunction

    // High when data plus received parity bit disagree with the chosen parity sense.
    function automatic logic parity_bad(input logic [N-1:0] d, input logic p);
        return (^d) ^ p ^ 1'(PARITY_ODD);
    endfunction

    // Two-flop synchroniser for din plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            ds_q      <= 1'b1;
            ds_prev_q <= 1'b1;
        end else begin
            sync1_q   <= din;
            ds_q      <= sync1_q;
            ds_prev_q <= ds_q;
        end
    end

    // Receive FSM with counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_HUNT;
            bit_cnt_q    <= '0;
            idx_q        <= '0;
            pre_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            shreg_q      <= '0;
            par_bad_q    <= 1'b0;
            data_q       <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            locked_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            // Consumer handshake; a word completing on this edge overrides below.
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                S_HUNT: begin
                    if (ds_q) begin
                        if (pre_cnt_q == PRE_LAST) begin
                            pre_cnt_q <= '0;
                            state_q   <= S_ARMED;
                            locked_q  <= 1'b1;
                        end else begin
                            pre_cnt_q <= pre_cnt_q + 1'b1;
                        end
                    end else begin
                        pre_cnt_q <= '0;
                    end
                end

                S_ARMED: begin
                    if (ds_prev_q && !ds_q) begin
                        state_q   <= S_START;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end

                // Half-bit wait puts this and every later sample mid-bit.
                S_START: begin
                    if (bit_cnt_q == HALF_M1) begin
                        bit_cnt_q <= '0;
                        if (ds_q) begin
                            state_q <= S_ARMED;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= S_DATA;
                            idx_q     <= '0;
                            par_bad_q <= 1'b0;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end

                S_DATA: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_q <= '0;
                        shreg_q   <= shift_in(shreg_q, ds_q);
                        if (idx_q == IDX_LAST) begin
                            idx_q      <= '0;
                            stop_cnt_q <= 1'b0;
                            state_q    <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_q <= '0;
                        par_bad_q <= parity_bad(shreg_q, ds_q);
                        state_q   <= S_STOP;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end

                S_STOP: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_q <= '0;
                        if (!ds_q) begin
                            // Broken framing: drop the word and relock from scratch.
                            frame_err_q <= 1'b1;
                            locked_q    <= 1'b0;
                            busy_q      <= 1'b0;
                            pre_cnt_q   <= '0;
                            state_q     <= S_HUNT;
                        end else if (stop_cnt_q == STOP_LAST) begin
                            state_q <= S_ARMED;
                            busy_q  <= 1'b0;
                            // Uses the pre-edge rx_valid so accept-and-reload works.
                            if (!rx_valid_q || rx_ready) begin
                                data_q       <= shreg_q;
                                parity_err_q <= par_bad_q;
                                rx_valid_q   <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q  <= S_HUNT;
                    locked_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign locked     = locked_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_rx_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_rx_frame_receiver
//   Directed bench for rx_frame_receiver. u_dut uses default parameters;
//   u_par enables even parity. Bits are 20 clk long, driven on negedges.
// -----------------------------------------------------------------------------
module tb_rx_frame_receiver;

    localparam int CPB = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] data_out;
    logic       rx_valid, parity_err, frame_err, overrun, locked, busy;

    logic       din_p = 1'b1;
    logic       rx_ready_p = 1'b0;
    logic [7:0] data_out_p;
    logic       rx_valid_p, parity_err_p, frame_err_p, overrun_p, locked_p, busy_p;

    int checks = 0;
    int errors = 0;

    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         ovr_cnt   = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] last_data = 8'h00;
    logic       last_par  = 1'b0;

    always #5 clk = ~clk;

    rx_frame_receiver u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_ready(rx_ready),
        .data_out(data_out), .rx_valid(rx_valid), .parity_err(parity_err),
        .frame_err(frame_err), .overrun(overrun), .locked(locked), .busy(busy)
    );

    rx_frame_receiver #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
        .clk(clk), .rst_n(rst_n), .din(din_p), .rx_ready(rx_ready_p),
        .data_out(data_out_p), .rx_valid(rx_valid_p), .parity_err(parity_err_p),
        .frame_err(frame_err_p), .overrun(overrun_p), .locked(locked_p), .busy(busy_p)
    );

    // Event monitor for the default instance, sampled on the inactive edge.
    always @(negedge clk) begin
        if (rx_valid && !valid_prev) begin
            valid_cnt <= valid_cnt + 1;
            last_data <= data_out;
            last_par  <= parity_err;
        end
        valid_prev <= rx_valid;
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (overrun)   ovr_cnt  <= ovr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input int clks);
        if (sel) din_p = v;
        else     din   = v;
        repeat (clks) @(negedge clk);
    endtask

    // start, 8 data bits LSB first, optional parity, one stop bit, short idle
    task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                              input logic par_v, input logic stop_v);
        drive(sel, 1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(sel, d[i], CPB);
        if (has_par) drive(sel, par_v, CPB);
        drive(sel, stop_v, CPB);
        drive(sel, 1'b1, 6);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rx_valid",  16'(rx_valid),   16'h0);
        chk("rst_data_out",  16'(data_out),   16'h0);
        chk("rst_locked",    16'(locked),     16'h0);
        chk("rst_busy",      16'(busy),       16'h0);
        chk("rst_frame_err", 16'(frame_err),  16'h0);
        chk("rst_overrun",   16'(overrun),    16'h0);
        chk("rst_par_err",   16'(parity_err), 16'h0);
        rst_n = 1'b1;

        // 1: preamble then 0xA5
        drive(1'b0, 1'b1, 12);
        chk("t1_locked", 16'(locked), 16'h1);
        chk("t1_busy_idle", 16'(busy), 16'h0);
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        chk("t1_valid_cnt", 16'(valid_cnt), 16'd1);
        chk("t1_data", 16'(last_data), 16'h00A5);
        chk("t1_par", 16'(last_par), 16'h0);
        chk("t1_valid_acked", 16'(rx_valid), 16'h0);
        chk("t1_ferr", 16'(ferr_cnt), 16'd0);

        // 2: 5-clk low glitch while armed
        drive(1'b0, 1'b0, 5);
        drive(1'b0, 1'b1, 30);
        chk("t2_valid_cnt", 16'(valid_cnt), 16'd1);
        chk("t2_locked", 16'(locked), 16'h1);
        chk("t2_busy", 16'(busy), 16'h0);
        chk("t2_ferr", 16'(ferr_cnt), 16'd0);

        // 3: parity instance, 0x03 with parity bit 1 (even parity -> error)
        chk("t3_locked", 16'(locked_p), 16'h1);
        send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
        chk("t3_valid", 16'(rx_valid_p), 16'h1);
        chk("t3_data", 16'(data_out_p), 16'h0003);
        chk("t3_par_err", 16'(parity_err_p), 16'h1);
        rx_ready_p = 1'b1;
        @(negedge clk);
        rx_ready_p = 1'b0;
        chk("t3_valid_acked", 16'(rx_valid_p), 16'h0);
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        chk("t3b_data", 16'(data_out_p), 16'h0007);
        chk("t3b_par_err", 16'(parity_err_p), 16'h0);

        // 4: stop bit low on 0x3C, then relock
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        chk("t4_ferr", 16'(ferr_cnt), 16'd1);
        chk("t4_valid_cnt", 16'(valid_cnt), 16'd1);
        chk("t4_locked", 16'(locked), 16'h0);
        send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("t4_hunt_ignored", 16'(valid_cnt), 16'd1);
        chk("t4_relocked", 16'(locked), 16'h1);
        send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
        chk("t4_valid_cnt2", 16'(valid_cnt), 16'd2);
        chk("t4_data2", 16'(last_data), 16'h00C3);

        // 5: overrun with consumer stalled
        rx_ready = 1'b0;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        chk("t5_valid", 16'(rx_valid), 16'h1);
        chk("t5_data", 16'(data_out), 16'h0011);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        chk("t5_ovr", 16'(ovr_cnt), 16'd1);
        chk("t5_data_kept", 16'(data_out), 16'h0011);
        chk("t5_valid_held", 16'(rx_valid), 16'h1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("t5_valid_acked", 16'(rx_valid), 16'h0);
        chk("t5_valid_cnt", 16'(valid_cnt), 16'd3);
        rx_ready = 1'b1;

        // 6: reset in the middle of the data bits
        drive(1'b0, 1'b0, CPB);
        drive(1'b0, 1'b1, CPB);
        drive(1'b0, 1'b0, CPB);
        drive(1'b0, 1'b1, CPB);
        chk("t6_busy_mid", 16'(busy), 16'h1);
        rst_n = 1'b0;
        din   = 1'b1;
        #1;
        chk("t6_rst_busy", 16'(busy), 16'h0);
        chk("t6_rst_locked", 16'(locked), 16'h0);
        chk("t6_rst_valid", 16'(rx_valid), 16'h0);
        chk("t6_rst_data", 16'(data_out), 16'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 12);
        chk("t6_locked", 16'(locked), 16'h1);
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        chk("t6_valid_cnt", 16'(valid_cnt), 16'd4);
        chk("t6_data", 16'(last_data), 16'h005A);
        chk("t6_ferr", 16'(ferr_cnt), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
